// File: rtl/pc_unit_if.sv
// Bus between the control FSM and the program-counter unit. The FSM drives the
// next-PC select, target operands and exception controls. The PC unit returns
// the current PC, the PC+INC value and the exception state.
interface pc_unit_if #(
  parameter int WD = 32
);
  logic          enable;
  logic [1:0]    pc_src;
  logic [WD-1:0] alu_result;
  logic [WD-1:0] alu_out;
  logic [25:0]   jump_index;
  logic [WD-1:0] reg_target;
  logic          exc_req;
  logic [4:0]    exc_code;
  logic          eret;
  logic [WD-1:0] pc;
  logic [WD-1:0] pc_plus;
  logic [WD-1:0] epc;
  logic [4:0]    cause;
  logic          in_exc;
  logic          pending;

  // Control side (FSM)
  modport master (
    output enable, pc_src, alu_result, alu_out, jump_index, reg_target,
           exc_req, exc_code, eret,
    input  pc, pc_plus, epc, cause, in_exc, pending
  );

  // PC unit side
  modport slave (
    input  enable, pc_src, alu_result, alu_out, jump_index, reg_target,
           exc_req, exc_code, eret,
    output pc, pc_plus, epc, cause, in_exc, pending
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the multicycle MIPS core. It holds the PC and picks
// the next PC from the sequential, ALU, jump and register sources. It also
// provides precise exception entry and return, with EPC/cause capture and a
// latched pending request. A second request is held off while the handler runs.
// A misaligned fetch target traps to the handler.
module pc_unit #(
  parameter int            WD        = 32,
  parameter logic [WD-1:0] RESET_VEC = WD'(32'h0040_0000),
  parameter logic [WD-1:0] EXC_VEC   = WD'(32'h8000_0180),
  parameter int            INC       = 4,
  parameter logic [4:0]    ADE_CODE  = 5'd4
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);

  localparam logic [WD-1:0] INC_W = WD'(INC);

  // Handler mode: the in_exc flag, kept as a two-state machine.
  typedef enum logic {
    MODE_RUN     = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_t;

  mode_t         mode_reg, mode_next;
  logic [WD-1:0] pc_reg, pc_next;
  logic [WD-1:0] epc_reg, epc_next;
  logic [4:0]    cause_reg, cause_next;
  logic          pending_reg, pending_next;
  logic [4:0]    pend_code_reg, pend_code_next;

  logic [WD-1:0] pc_plus_w;
  logic [WD-1:0] jump_target;
  logic [WD-1:0] nxt;
  logic          take_exc;
  logic          do_ret;
  logic          misaligned;

  // Sequential successor, jump target and next-PC source mux.
  always_comb begin
    pc_plus_w   = pc_reg + INC_W;
    jump_target = {pc_plus_w[WD-1:28], bus.jump_index, 2'b00};
    nxt         = bus.alu_result;
    case (bus.pc_src)
      2'd0:    nxt = bus.alu_result;
      2'd1:    nxt = bus.alu_out;
      2'd2:    nxt = jump_target;
      default: nxt = bus.reg_target;
    endcase
  end

  // Next-state logic. Exception entry has priority over return, return over
  // the misalignment trap, and the trap over the normal PC update.
  always_comb begin
    pc_next        = pc_reg;
    epc_next       = epc_reg;
    cause_next     = cause_reg;
    mode_next      = mode_reg;
    pending_next   = pending_reg;
    pend_code_next = pend_code_reg;

    take_exc   = (pending_reg || bus.exc_req) && (mode_reg == MODE_RUN);
    do_ret     = bus.eret && (mode_reg == MODE_HANDLER);
    misaligned = (nxt[1:0] != 2'b00) && (mode_reg == MODE_RUN);

    // The first request is latched. Later requests are dropped until it is taken.
    if (!pending_reg && bus.exc_req) begin
      pending_next   = 1'b1;
      pend_code_next = bus.exc_code;
    end

    if (bus.enable) begin
      if (take_exc) begin
        epc_next     = pc_reg;
        cause_next   = pending_reg ? pend_code_reg : bus.exc_code;
        pc_next      = EXC_VEC;
        mode_next    = MODE_HANDLER;
        pending_next = 1'b0;
      end else if (do_ret) begin
        // A request held during the handler stays pending and is taken on
        // the next enabled cycle.
        pc_next   = epc_reg;
        mode_next = MODE_RUN;
      end else if (misaligned) begin
        epc_next   = pc_reg;
        cause_next = ADE_CODE;
        pc_next    = EXC_VEC;
        mode_next  = MODE_HANDLER;
      end else begin
        // Inside the handler a misaligned target is trusted and followed.
        pc_next = nxt;
      end
    end
  end

  // State registers. Reset clears everything, including an active handler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= RESET_VEC;
      epc_reg       <= '0;
      cause_reg     <= '0;
      mode_reg      <= MODE_RUN;
      pending_reg   <= 1'b0;
      pend_code_reg <= '0;
    end else begin
      pc_reg        <= pc_next;
      epc_reg       <= epc_next;
      cause_reg     <= cause_next;
      mode_reg      <= mode_next;
      pending_reg   <= pending_next;
      pend_code_reg <= pend_code_next;
    end
  end

  assign bus.pc      = pc_reg;
  assign bus.pc_plus = pc_plus_w;
  assign bus.epc     = epc_reg;
  assign bus.cause   = cause_reg;
  assign bus.in_exc  = (mode_reg == MODE_HANDLER);
  assign bus.pending = pending_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. It runs directed steps from the test plan,
// then randomized cycles. Every cycle is compared against a behavioural model.
module tb_pc_unit;
  localparam logic [31:0] RST_V = 32'h0040_0000;
  localparam logic [31:0] EXC_V = 32'h8000_0180;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  string step;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [4:0]  m_cause, m_pcode;
  logic        m_in_exc, m_pend;

  pc_unit_if #(.WD(32)) bus ();

  pc_unit #(.WD(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s got=%h want=%h", step, tag, obs, exp);
    end
  endtask

  // Model one clock edge from the behavioural rules, using the current inputs.
  task automatic model_edge();
    logic [31:0] nxt;
    if (reset) begin
      m_pc = RST_V; m_epc = 0; m_cause = 0; m_in_exc = 0; m_pend = 0; m_pcode = 0;
      return;
    end
    case (bus.pc_src)
      2'd0: nxt = bus.alu_result;
      2'd1: nxt = bus.alu_out;
      2'd2: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, bus.jump_index} * 32'd4);
      default: nxt = bus.reg_target;
    endcase
    if (bus.enable) begin
      if ((m_pend || bus.exc_req) && !m_in_exc) begin
        m_epc = m_pc;
        m_cause = m_pend ? m_pcode : bus.exc_code;
        m_pc = EXC_V;
        m_in_exc = 1;
        m_pend = 0;
        return;
      end else if (bus.eret && m_in_exc) begin
        m_pc = m_epc;
        m_in_exc = 0;
      end else if ((nxt % 4) != 0 && !m_in_exc) begin
        m_epc = m_pc;
        m_cause = 5'd4;
        m_pc = EXC_V;
        m_in_exc = 1;
      end else begin
        m_pc = nxt;
      end
    end
    if (bus.exc_req && !m_pend) begin
      m_pend = 1;
      m_pcode = bus.exc_code;
    end
  endtask

  // One clock edge: update the model, then compare every output against it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", bus.pc, m_pc);
    check("pc_plus", bus.pc_plus, m_pc + 32'd4);
    check("epc", bus.epc, m_epc);
    check("cause", {27'd0, bus.cause}, {27'd0, m_cause});
    check("in_exc", {31'd0, bus.in_exc}, {31'd0, m_in_exc});
    check("pending", {31'd0, bus.pending}, {31'd0, m_pend});
  endtask

  task automatic idle();
    reset = 0;
    bus.enable = 0; bus.pc_src = 0; bus.alu_result = 0; bus.alu_out = 0;
    bus.jump_index = 0; bus.reg_target = 0; bus.exc_req = 0; bus.exc_code = 0;
    bus.eret = 0;
  endtask

  task automatic fetch();
    idle();
    bus.enable = 1; bus.pc_src = 0; bus.alu_result = m_pc + 32'd4;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    m_pc = 0; m_epc = 0; m_cause = 0; m_in_exc = 0; m_pend = 0; m_pcode = 0;
    idle();

    step = "reset";
    reset = 1; bus.exc_req = 1; bus.enable = 1;
    tick(); tick();
    check("pc_rst", bus.pc, RST_V);
    check("pcp_rst", bus.pc_plus, 32'h0040_0004);
    check("epc_rst", bus.epc, 32'd0);

    step = "fetch";
    fetch(); check("f1", bus.pc, 32'h0040_0004);
    fetch(); check("f2", bus.pc, 32'h0040_0008);
    fetch(); check("f3", bus.pc, 32'h0040_000C);
    check("f_in_exc", {31'd0, bus.in_exc}, 32'd0);
    fetch();

    step = "hold";
    idle(); bus.pc_src = 0; bus.alu_result = 32'h1234_5678;
    for (int i = 0; i < 4; i++) tick();
    check("hold_pc", bus.pc, 32'h0040_0010);

    step = "jump";
    idle(); bus.enable = 1; bus.pc_src = 2; bus.jump_index = 26'h010_0005;
    tick();
    check("jump_pc", bus.pc, 32'h0040_0014);
    fetch(); fetch(); fetch();

    step = "exc_entry";
    idle(); bus.enable = 1; bus.exc_req = 1; bus.exc_code = 5'd12;
    bus.alu_result = 32'h0040_0024;
    tick();
    check("exc_pc", bus.pc, EXC_V);
    check("exc_epc", bus.epc, 32'h0040_0020);
    check("exc_cause", {27'd0, bus.cause}, 32'd12);
    fetch(); fetch();

    step = "eret";
    idle(); bus.enable = 1; bus.eret = 1; bus.alu_result = 32'h0000_0001;
    tick();
    check("ret_pc", bus.pc, 32'h0040_0020);
    check("ret_in_exc", {31'd0, bus.in_exc}, 32'd0);

    step = "nested";
    idle(); bus.enable = 1; bus.exc_req = 1; bus.exc_code = 5'd12;
    tick();
    idle(); bus.exc_req = 1; bus.exc_code = 5'd8;
    tick();
    check("nest_pend", {31'd0, bus.pending}, 32'd1);
    check("nest_pc", bus.pc, EXC_V);
    idle(); bus.exc_req = 1; bus.exc_code = 5'd9;
    tick();
    idle(); bus.enable = 1; bus.eret = 1;
    tick();
    check("nest_ret_pc", bus.pc, 32'h0040_0020);
    fetch();
    check("nest_take_pc", bus.pc, EXC_V);
    check("nest_cause", {27'd0, bus.cause}, 32'd8);
    check("nest_pend0", {31'd0, bus.pending}, 32'd0);

    step = "ret_and_req";
    idle(); bus.enable = 1; bus.eret = 1; bus.exc_req = 1; bus.exc_code = 5'd13;
    tick();
    check("rr_pc", bus.pc, 32'h0040_0020);
    check("rr_pend", {31'd0, bus.pending}, 32'd1);
    fetch();
    check("rr_cause", {27'd0, bus.cause}, 32'd13);
    idle(); bus.enable = 1; bus.eret = 1;
    tick();
    for (int i = 0; i < 4; i++) fetch();

    step = "eret_ignored";
    idle(); bus.enable = 1; bus.eret = 1; bus.pc_src = 1; bus.alu_out = 32'h0040_0030;
    tick();
    check("ign_pc", bus.pc, 32'h0040_0030);

    step = "misalign";
    idle(); bus.enable = 1; bus.pc_src = 3; bus.reg_target = 32'h0040_0102;
    tick();
    check("ade_pc", bus.pc, EXC_V);
    check("ade_epc", bus.epc, 32'h0040_0030);
    check("ade_cause", {27'd0, bus.cause}, 32'd4);
    tick();
    check("ade_trusted", bus.pc, 32'h0040_0102);

    step = "wrap";
    idle(); bus.enable = 1; bus.eret = 1;
    tick();
    idle(); bus.enable = 1; bus.pc_src = 3; bus.reg_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    check("wrap_plus", bus.pc_plus, 32'd0);
    fetch();
    check("wrap_pc", bus.pc, 32'd0);
    check("wrap_in_exc", {31'd0, bus.in_exc}, 32'd0);

    step = "mid_reset";
    idle(); bus.enable = 1; bus.exc_req = 1; bus.exc_code = 5'd3;
    tick();
    idle(); bus.exc_req = 1; bus.exc_code = 5'd5;
    tick();
    reset = 1; bus.enable = 1; bus.exc_req = 1; bus.eret = 1;
    tick();
    check("mr_pc", bus.pc, RST_V);
    check("mr_in_exc", {31'd0, bus.in_exc}, 32'd0);
    check("mr_pend", {31'd0, bus.pending}, 32'd0);

    step = "random";
    for (int n = 0; n < 400; n++) begin
      idle();
      reset          = ($urandom_range(0, 49) == 0);
      bus.enable     = $urandom_range(0, 3) != 0;
      bus.pc_src     = 2'($urandom_range(0, 3));
      bus.alu_result = ($urandom_range(0, 1) != 0) ? m_pc + 32'd4 : $urandom;
      bus.alu_out    = $urandom & 32'hFFFF_FFFC;
      bus.jump_index = 26'($urandom);
      bus.reg_target = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.exc_req    = ($urandom_range(0, 7) == 0);
      bus.exc_code   = 5'($urandom_range(0, 31));
      bus.eret       = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle MIPS core, replacing the plain enable register. It holds the PC, selects the next PC among sequential, ALU, jump and register targets, and adds precise exception entry and return: EPC/cause capture, a latched pending request, a nested-exception guard and a misaligned-target trap. The control FSM drives it, and it feeds the instruction-memory address and the PC+4 path.

## Interface
- WD, 32: datapath width; legal values are ≥ 32.
- RESET_VEC, 32'h0040_0000: PC value after reset.
- EXC_VEC, 32'h8000_0180: exception handler entry address.
- INC, 4: sequential increment.
- ADE_CODE, 5'd4: cause code written on a misaligned target.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  PC write strobe from the FSM; the PC holds while low.
- pc_src  in  2  next-PC select: 0 = alu_result, 1 = alu_out, 2 = jump, 3 = reg_target.
- alu_result  in  WD  combinational ALU output (PC+4 in fetch).
- alu_out  in  WD  registered ALU output (branch target).
- jump_index  in  26  instr[25:0].
- reg_target  in  WD  rs value for jr/jalr.
- exc_req  in  1  exception request; sampled every cycle.
- exc_code  in  5  cause code qualifying exc_req.
- eret  in  1  return-from-exception request; qualified by enable.
- pc  out  WD  current PC.
- pc_plus  out  WD  pc + INC, wrapping modulo 2^WD; combinational.
- epc  out  WD  saved exception PC.
- cause  out  5  last exception cause.
- in_exc  out  1  handler active; further exceptions are held pending.
- pending  out  1  an exception is latched but not yet taken.

## Operation
- **Jump target:** {pc_plus[WD-1:28], jump_index, 2'b00}.
- **Next-PC candidate nxt:** the pc_src mux output.
- **Pending latch:**
  - A cycle with exc_req=1 and pending=0 sets pending=1 and stores exc_code in the internal pend_code.
  - Further requests while pending=1 are dropped; the first request wins.
- **Priority on an enable=1 cycle, highest first:**
  1. Take exception: (pending=1 or exc_req=1) and in_exc=0. Then epc←pc, cause←code, pc←EXC_VEC, in_exc←1, pending←0. The code is pend_code if pending=1, otherwise exc_code.
  2. Return: eret=1 and in_exc=1. Then pc←epc, in_exc←0. pending is unchanged; a held request is taken on the next enable=1 cycle.
  3. Misaligned target: nxt[1:0]≠0 and in_exc=0. Then epc←pc, cause←ADE_CODE, pc←EXC_VEC, in_exc←1.
  4. Normal: pc←nxt. This includes a misaligned nxt while in_exc=1; the handler is trusted and no trap is raised.
- eret=1 with in_exc=0 is ignored; the normal path applies.
- **enable=0 cycle:**
  - pc, epc, cause and in_exc hold.
  - Only the pending latch may change.
- exc_req with in_exc=1 sets pending but is not taken until after the return.

## Timing
- **Reset:**
  - All outputs are registered except pc_plus.
  - reset=1 at an edge gives pc=RESET_VEC, epc=0, cause=0, in_exc=0, pending=0, pend_code=0.
  - pc_plus then reads RESET_VEC+INC.
  - reset overrides enable, exc_req and eret in the same cycle.
  - Reset in the middle of handler execution aborts the handler; the state is fully cleared.
- **Latency:**
  - One edge from an enable=1 cycle to the new pc.
  - A same-cycle exc_req with enable=1 is taken at that edge, with zero extra latency.
  - A request that arrives while enable=0 is taken at the first enable=1 edge.
- **Wrap-around:** pc=2^WD−4 with pc_src=0 and alu_result=pc_plus gives pc=0 at the next edge. Zero is aligned, so no trap.
- **Simultaneous events:**
  - exc_req+eret with in_exc=1: the return wins, pending←1, and the exception is taken on the next enable=1 edge.
  - exc_req with reset: reset wins and pending=0.

## Test plan
- **Reset and fetch:** reset=1 for 2 cycles, then enable=1, pc_src=0, alu_result=pc_plus for 3 cycles. Required: pc = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; epc=0; in_exc=0.
- **Hold and jump:**
  - enable=0 for 4 cycles: pc holds.
  - Then with pc=0x0040_0010: pc_src=2, jump_index=26'h010_0005, enable=1. Required: pc=0x0040_0014.
- **Exception entry and return:**
  - With pc=0x0040_0020, in the same cycle: exc_req=1, exc_code=12, enable=1. Required: pc=0x8000_0180, epc=0x0040_0020, cause=12, in_exc=1.
  - Later eret=1, enable=1. Required: pc=0x0040_0020, in_exc=0.
- **Pending/nested:**
  - exc_req=1, code 8, while in_exc=1 and enable=0. Required: pending=1; pc unchanged.
  - eret with enable=1. Required: pc=epc.
  - Next enable=1 cycle. Required: pc=0x8000_0180, cause=8, pending=0.
- **Misaligned trap:** pc=0x0040_0030, pc_src=3, reg_target=0x0040_0102, enable=1. Required: pc=0x8000_0180, epc=0x0040_0030, cause=4. Repeating with in_exc=1 instead gives pc=0x0040_0102.
- **Wrap and mid-handler reset:**
  - pc=0xFFFF_FFFC with sequential step. Required: pc=0x0000_0000.
  - Then, inside a handler, reset=1 together with exc_req=1. Required: pc=0x0040_0000, in_exc=0, pending=0.
